// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory bus controller state encoding and the
// all-zero NOP instruction used whenever the instruction register is cleared.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } bus_state_t;

    localparam logic [15:0] NOP_INSN = 16'h0000;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory handshake: cleared when a request starts,
// advanced on each not-ready cycle, and flags the last permitted wait cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns decoder request strobes into a ready-based
// memory handshake, loads ISR or rd_data on reads, and pulses ACK on completion.
module mem_bus_ctrl
    import cpu_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MREQ_N,
    input  logic          R_W_N,
    input  logic          MIS,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          err_clr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy,
    output logic          ACK,
    output logic [DW-1:0] ISR,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          err
);

    bus_state_t state;
    logic       is_read;
    logic       is_fetch;
    logic       timer_expire;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE && !MREQ_N),
        .enable (state == REQ && !mem_rdy),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ACK       <= 1'b0;
            ISR       <= DW'(NOP_INSN);
            rd_data   <= '0;
            err       <= 1'b0;
            is_read   <= 1'b0;
            is_fetch  <= 1'b0;
        end else begin
            // A timeout later in this block overrides the clear on the same edge.
            if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!MREQ_N) begin
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        mem_we    <= ~R_W_N;
                        is_read   <= R_W_N;
                        is_fetch  <= MIS;
                        mem_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rdy) begin
                        if (is_read && is_fetch) begin
                            ISR <= mem_rdata;
                        end else if (is_read) begin
                            rd_data <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        ACK     <= 1'b1;
                        state   <= DONE;
                    end else if (timer_expire) begin
                        // Aborted fetch leaves a NOP so the core never runs stale code.
                        if (is_read && is_fetch) begin
                            ISR <= DW'(NOP_INSN);
                        end
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        ACK     <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    ACK   <= 1'b0;
                    state <= MREQ_N ? IDLE : HOLD;
                end
                HOLD: begin
                    if (MREQ_N) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_mem_bus_ctrl;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          MREQ_N = 1'b1;
    logic          R_W_N = 1'b1;
    logic          MIS = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          err_clr = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rdy = 1'b0;
    logic          ACK;
    logic [DW-1:0] ISR;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_isr = '0;
    logic [DW-1:0] m_rd  = '0;
    logic          m_err = 1'b0;

    mem_bus_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .MREQ_N    (MREQ_N),
        .R_W_N     (R_W_N),
        .MIS       (MIS),
        .addr      (addr),
        .wdata     (wdata),
        .err_clr   (err_clr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .ACK       (ACK),
        .ISR       (ISR),
        .rd_data   (rd_data),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Request cycles seen by memory: wait cycles plus the ready cycle, capped by the abort.
    function automatic int exp_req_cycles(input int wait_n);
        return (wait_n < TIMEOUT) ? wait_n + 1 : TIMEOUT;
    endfunction

    task automatic apply_model(input logic rw_n, input logic mis, input logic [DW-1:0] rd,
                               input int wait_n);
        bit timed_out;
        timed_out = (wait_n >= TIMEOUT);
        if (rw_n && !timed_out) begin
            if (mis) m_isr = rd;
            else     m_rd  = rd;
        end
        if (rw_n && mis && timed_out) m_isr = '0;
        if (timed_out) m_err = 1'b1;
    endtask

    // Drives one request and monitors the bus for a bounded window; reports observations only.
    task automatic run_txn(input logic rw_n, input logic mis, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                           input int wait_n, input int hold_n, input bit clr_at_abort,
                           output int n_req, output int n_ack, output bit ack_ok,
                           output bit bus_ok);
        int  last_req, first_ack, len;
        bit  released;
        n_req = 0; n_ack = 0; bus_ok = 1'b1; last_req = -1; first_ack = -1; released = 1'b0;
        len = exp_req_cycles(wait_n) + hold_n + 6;
        @(negedge clk);
        MREQ_N = 1'b0; R_W_N = rw_n; MIS = mis; addr = a; wdata = wd; mem_rdy = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            err_clr = 1'b0;
            if (mem_req) begin
                n_req++;
                last_req = i;
                if (mem_addr !== a || mem_we !== ~rw_n || mem_wdata !== wd) bus_ok = 1'b0;
            end
            if (ACK) begin
                n_ack++;
                if (first_ack < 0) first_ack = i;
            end
            if (mem_req) begin
                mem_rdy   = (n_req == wait_n + 1);
                mem_rdata = mem_rdy ? rd : DW'($urandom);
                if (clr_at_abort && n_req == TIMEOUT) err_clr = 1'b1;
                R_W_N = 1'($urandom); MIS = 1'($urandom);
                addr  = AW'($urandom); wdata = DW'($urandom);
            end else begin
                mem_rdy   = 1'($urandom);
                mem_rdata = DW'($urandom);
            end
            if (first_ack >= 0 && !released && i >= first_ack + hold_n) begin
                MREQ_N = 1'b1;
                released = 1'b1;
            end
        end
        MREQ_N = 1'b1;
        mem_rdy = 1'b0;
        ack_ok = (n_ack == 1) && (first_ack == last_req + 1);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({mem_req, mem_we, ACK, busy, err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, ACK, busy, err});
        end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL reset_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
        end
        checks++; if (ISR !== 16'h0000 || rd_data !== '0) begin
            errors++; $display("FAIL reset_regs: got ISR %h rd_data %h expected 0", ISR, rd_data);
        end
        reset = 1'b1;
    endtask

    task automatic test_fetch_zero_wait;
        int nr, na; bit ak, bo;
        run_txn(1'b1, 1'b1, 16'h0010, 16'h0000, 16'hA5C3, 0, 0, 1'b0, nr, na, ak, bo);
        apply_model(1'b1, 1'b1, 16'hA5C3, 0);
        checks++; if (nr !== 1) begin errors++; $display("FAIL fetch_req_cycles: got %0d expected 1", nr); end
        checks++; if (!ak) begin errors++; $display("FAIL fetch_ack: got %0d pulses/bad timing expected 1", na); end
        checks++; if (!bo) begin errors++; $display("FAIL fetch_bus: got bad addr/we expected addr 0010 we 0"); end
        checks++; if (ISR !== m_isr) begin errors++; $display("FAIL fetch_isr: got %h expected %h", ISR, m_isr); end
        checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL fetch_rd: got %h expected %h", rd_data, m_rd); end
    endtask

    task automatic test_read_wait;
        int nr, na; bit ak, bo;
        run_txn(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1234, 3, 0, 1'b0, nr, na, ak, bo);
        apply_model(1'b1, 1'b0, 16'h1234, 3);
        checks++; if (nr !== 4) begin errors++; $display("FAIL read_req_cycles: got %0d expected 4", nr); end
        checks++; if (!ak || !bo) begin errors++; $display("FAIL read_handshake: got ack %0d bus %0d expected 1 1", na, bo); end
        checks++; if (rd_data !== m_rd || ISR !== m_isr) begin
            errors++; $display("FAIL read_regs: got rd %h ISR %h expected %h %h", rd_data, ISR, m_rd, m_isr);
        end
    endtask

    task automatic test_write;
        int nr, na; bit ak, bo;
        run_txn(1'b0, 1'b0, 16'h00FF, 16'hBEEF, 16'h5555, 2, 0, 1'b0, nr, na, ak, bo);
        apply_model(1'b0, 1'b0, 16'h5555, 2);
        checks++; if (nr !== 3) begin errors++; $display("FAIL write_req_cycles: got %0d expected 3", nr); end
        checks++; if (!bo) begin errors++; $display("FAIL write_bus: got bad we/addr/wdata expected 1/00FF/BEEF"); end
        checks++; if (!ak) begin errors++; $display("FAIL write_ack: got %0d pulses/bad timing expected 1", na); end
        checks++; if (rd_data !== m_rd || ISR !== m_isr) begin
            errors++; $display("FAIL write_regs: got rd %h ISR %h expected %h %h", rd_data, ISR, m_rd, m_isr);
        end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL write_we_idle: got %b expected 0", mem_we); end
    endtask

    task automatic test_timeout;
        int nr, na; bit ak, bo;
        run_txn(1'b1, 1'b1, 16'h0400, 16'h0000, 16'h7777, TIMEOUT + 5, 0, 1'b0, nr, na, ak, bo);
        apply_model(1'b1, 1'b1, 16'h7777, TIMEOUT + 5);
        checks++; if (nr !== TIMEOUT) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected %0d", nr, TIMEOUT); end
        checks++; if (!ak) begin errors++; $display("FAIL timeout_ack: got %0d pulses/bad timing expected 1", na); end
        checks++; if (err !== m_err || ISR !== m_isr) begin
            errors++; $display("FAIL timeout_err_isr: got err %b ISR %h expected %b %h", err, ISR, m_err, m_isr);
        end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; m_err = 1'b0;
        checks++; if (err !== m_err) begin errors++; $display("FAIL err_clear: got %b expected %b", err, m_err); end
    endtask

    task automatic test_timeout_boundary;
        int nr, na; bit ak, bo;
        // Ready arrives on the edge that would otherwise abort: ready wins.
        run_txn(1'b1, 1'b0, 16'h0500, 16'h0000, 16'hC0DE, TIMEOUT - 1, 0, 1'b0, nr, na, ak, bo);
        apply_model(1'b1, 1'b0, 16'hC0DE, TIMEOUT - 1);
        checks++; if (nr !== TIMEOUT || !ak) begin
            errors++; $display("FAIL ready_on_timeout: got req %0d ack %0d expected %0d 1", nr, na, TIMEOUT);
        end
        checks++; if (err !== m_err || rd_data !== m_rd) begin
            errors++; $display("FAIL ready_on_timeout_regs: got err %b rd %h expected %b %h", err, rd_data, m_err, m_rd);
        end
        // Timeout with err_clr on the same edge: set has priority.
        run_txn(1'b1, 1'b0, 16'h0600, 16'h0000, 16'h9999, TIMEOUT + 2, 0, 1'b1, nr, na, ak, bo);
        apply_model(1'b1, 1'b0, 16'h9999, TIMEOUT + 2);
        checks++; if (err !== m_err || rd_data !== m_rd) begin
            errors++; $display("FAIL err_set_priority: got err %b rd %h expected %b %h", err, rd_data, m_err, m_rd);
        end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; m_err = 1'b0;
    endtask

    task automatic test_held_request;
        int nr, na; bit ak, bo;
        run_txn(1'b1, 1'b0, 16'h0700, 16'h0000, 16'h4321, 1, 10, 1'b0, nr, na, ak, bo);
        apply_model(1'b1, 1'b0, 16'h4321, 1);
        checks++; if (nr !== 2 || na !== 1 || !ak) begin
            errors++; $display("FAIL held_single_txn: got req %0d ack %0d expected 2 1", nr, na);
        end
        run_txn(1'b1, 1'b1, 16'h0800, 16'h0000, 16'h8765, 0, 0, 1'b0, nr, na, ak, bo);
        apply_model(1'b1, 1'b1, 16'h8765, 0);
        checks++; if (nr !== 1 || !ak || ISR !== m_isr) begin
            errors++; $display("FAIL held_second_txn: got req %0d ack %0d ISR %h expected 1 1 %h", nr, na, ISR, m_isr);
        end
    endtask

    task automatic test_reset_mid_op;
        int nr, na, acks; bit ak, bo;
        @(negedge clk);
        MREQ_N = 1'b0; R_W_N = 1'b1; MIS = 1'b1; addr = 16'h0900; mem_rdy = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || ACK !== 1'b0 || ISR !== 16'h0000) begin
            errors++; $display("FAIL reset_mid_op: got req %b busy %b ack %b ISR %h expected 0 0 0 0000",
                               mem_req, busy, ACK, ISR);
        end
        m_isr = '0; m_rd = '0; m_err = 1'b0;
        MREQ_N = 1'b1;
        @(negedge clk); reset = 1'b1;
        acks = 0;
        repeat (3) begin @(negedge clk); if (ACK) acks++; end
        checks++; if (acks !== 0) begin errors++; $display("FAIL reset_no_ack: got %0d expected 0", acks); end
        run_txn(1'b1, 1'b0, 16'h0A00, 16'h0000, 16'h2468, 2, 0, 1'b0, nr, na, ak, bo);
        apply_model(1'b1, 1'b0, 16'h2468, 2);
        checks++; if (nr !== 3 || !ak || rd_data !== m_rd) begin
            errors++; $display("FAIL reset_recover: got req %0d ack %0d rd %h expected 3 1 %h", nr, na, rd_data, m_rd);
        end
    endtask

    task automatic test_random;
        int nr, na, w, h; bit ak, bo;
        logic rw, ms;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        for (int t = 0; t < 25; t++) begin
            rw = 1'($urandom); ms = 1'($urandom);
            a = AW'($urandom); wd = DW'($urandom); rd = DW'($urandom);
            w = $urandom_range(0, TIMEOUT + 2);
            h = $urandom_range(0, 3);
            run_txn(rw, ms, a, wd, rd, w, h, 1'b0, nr, na, ak, bo);
            apply_model(rw, ms, rd, w);
            checks++; if (nr !== exp_req_cycles(w) || !ak || !bo) begin
                errors++; $display("FAIL rand_%0d_handshake: got req %0d ack %0d bus %0d expected %0d 1 1",
                                   t, nr, na, bo, exp_req_cycles(w));
            end
            checks++; if (ISR !== m_isr || rd_data !== m_rd || err !== m_err || busy !== 1'b0) begin
                errors++; $display("FAIL rand_%0d_regs: got ISR %h rd %h err %b busy %b expected %h %h %b 0",
                                   t, ISR, rd_data, err, busy, m_isr, m_rd, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_read_wait();
        test_write();
        test_timeout();
        test_timeout_boundary();
        test_held_request();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
